// File: rtl/caches_types_pkg.sv
// Cache/bus shared types: coherence bus controller states and block geometry.
package caches_types_pkg;
  localparam int BLOCK_WORDS = 2;

  typedef enum logic [3:0] {
    BUS_IDLE  = 4'd0,
    BUS_SNOOP = 4'd1,
    BUS_FWD0  = 4'd2,
    BUS_FWD1  = 4'd3,
    BUS_LD0   = 4'd4,
    BUS_LD1   = 4'd5,
    BUS_WB0   = 4'd6,
    BUS_WB1   = 4'd7,
    BUS_INV   = 4'd8,
    BUS_IF    = 4'd9
  } bus_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// CPU-side shared types: RAM port status as reported by the RAM model.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the core numbered rr wins if it requests,
// otherwise the other core.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       idx,
  output logic       vld
);
  assign idx = req[rr] ? rr : ~rr;
  assign vld = |req;
endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI snooping bus controller sharing one RAM port between the
// icaches and dcaches; dcache blocks are moved one word per RAM access.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
  import caches_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NCPU   = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NCPU-1:0]               iREN,
  input  logic [NCPU-1:0][WORD_W-1:0]   iaddr,
  output logic [NCPU-1:0]               iwait,
  output logic [NCPU-1:0][WORD_W-1:0]   iload,
  input  logic [NCPU-1:0]               dREN,
  input  logic [NCPU-1:0]               dWEN,
  input  logic [NCPU-1:0][WORD_W-1:0]   daddr,
  input  logic [NCPU-1:0][WORD_W-1:0]   dstore,
  output logic [NCPU-1:0]               dwait,
  output logic [NCPU-1:0][WORD_W-1:0]   dload,
  input  logic [NCPU-1:0]               cctrans,
  input  logic [NCPU-1:0]               ccwrite,
  input  logic [NCPU-1:0]               cchit,
  output logic [NCPU-1:0]               ccwait,
  output logic [NCPU-1:0]               ccinv,
  output logic [NCPU-1:0][WORD_W-1:0]   ccsnoopaddr,
  output logic                          ramREN,
  output logic                          ramWEN,
  output logic [WORD_W-1:0]             ramaddr,
  output logic [WORD_W-1:0]             ramstore,
  input  logic [WORD_W-1:0]             ramload,
  input  ramstate_t                     ramstate
);

  if (NCPU != 2) begin : g_ncpu_check
    $error("coherence_bus_ctrl supports exactly two cores");
  end

  bus_state_t state;
  logic       gnt;
  logic       rr;
  logic       o;
  logic       d_idx, d_vld;
  logic       i_idx, i_vld;
  logic       acc;

  assign o   = ~gnt;
  assign acc = (ramstate == ACCESS);

  rr_arb2 u_darb (.req(cctrans), .rr(rr), .idx(d_idx), .vld(d_vld));
  rr_arb2 u_iarb (.req(iREN),    .rr(rr), .idx(i_idx), .vld(i_vld));

  // Any dcache transaction outranks instruction fetch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= BUS_IDLE;
      gnt   <= 1'b0;
      rr    <= 1'b0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (d_vld) begin
            gnt <= d_idx;
            if (dWEN[d_idx])         state <= BUS_WB0;
            else if (dREN[d_idx])    state <= BUS_SNOOP;
            else if (ccwrite[d_idx]) state <= BUS_INV;
          end else if (i_vld) begin
            gnt   <= i_idx;
            state <= BUS_IF;
          end
        end
        BUS_SNOOP: state <= cchit[o] ? BUS_FWD0 : BUS_LD0;
        BUS_FWD0:  if (acc) state <= BUS_FWD1;
        BUS_LD0:   if (acc) state <= BUS_LD1;
        BUS_WB0:   if (acc) state <= BUS_WB1;
        BUS_FWD1, BUS_LD1, BUS_WB1, BUS_IF: begin
          if (acc) begin
            state <= BUS_IDLE;
            rr    <= o;
          end
        end
        BUS_INV: begin
          state <= BUS_IDLE;
          rr    <= o;
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      BUS_SNOOP: begin
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[gnt];
        ccinv[o]       = ccwrite[gnt];
      end
      // Modified copy goes to the requester and to RAM in the same access.
      BUS_FWD0, BUS_FWD1: begin
        ccwait[o]  = 1'b1;
        ramWEN     = 1'b1;
        ramaddr    = daddr[o];
        ramstore   = dstore[o];
        dload[gnt] = dstore[o];
        if (acc) begin
          dwait[gnt] = 1'b0;
          dwait[o]   = 1'b0;
        end
      end
      BUS_LD0, BUS_LD1: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[gnt];
        dload[gnt] = ramload;
        if (acc) dwait[gnt] = 1'b0;
      end
      BUS_WB0, BUS_WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[gnt];
        ramstore = dstore[gnt];
        if (acc) dwait[gnt] = 1'b0;
      end
      BUS_INV: begin
        ccwait[o]      = 1'b1;
        ccinv[o]       = 1'b1;
        ccsnoopaddr[o] = daddr[gnt];
        dwait[gnt]     = 1'b0;
      end
      BUS_IF: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[gnt];
        iload[gnt] = ramload;
        if (acc) iwait[gnt] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: arbitration vector table followed by
// multi-cycle block transfer, forward, upgrade and reset sequences.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic              CLK;
  logic              RST;
  logic [1:0]        iREN;
  logic [1:0][31:0]  iaddr;
  logic [1:0]        iwait;
  logic [1:0][31:0]  iload;
  logic [1:0]        dREN, dWEN;
  logic [1:0][31:0]  daddr, dstore;
  logic [1:0]        dwait;
  logic [1:0][31:0]  dload;
  logic [1:0]        cctrans, ccwrite, cchit;
  logic [1:0]        ccwait, ccinv;
  logic [1:0][31:0]  ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  ramstate_t         ramstate;

  coherence_bus_ctrl #(.WORD_W(32), .NCPU(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .cchit(cchit),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: lat BUSY cycles then one ACCESS cycle per word; writes are logged.
  int          lat;
  int          ram_cnt;
  logic [31:0] mem [0:255];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always_comb begin
    if (!(ramREN || ramWEN))  ramstate = FREE;
    else if (ram_cnt >= lat)  ramstate = ACCESS;
    else                      ramstate = BUSY;
  end
  assign ramload = mem[ramaddr[9:2]];

  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && ramstate == ACCESS) begin
      ram_cnt <= 0;
      if (ramWEN) begin
        wa_q.push_back(ramaddr);
        wd_q.push_back(ramstore);
      end
    end else if (ramREN || ramWEN) begin
      ram_cnt <= ram_cnt + 1;
    end else begin
      ram_cnt <= 0;
    end
  end

  logic [1:0] hit_en;
  assign cchit = hit_en & ccwait;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  cct, ccw, ren, wen, iren;
    logic [1:0]  e_ccwait, e_ccinv, e_dwait, e_iwait;
    logic        e_ren, e_wen;
    logic [31:0] e_addr;
  } vec_t;
  vec_t tbl [9];

  // Simple per-core cache behaviour for the multi-cycle sequences.
  logic [1:0]  d_active, i_active;
  int          d_cnt  [2];
  int          d_need [2];
  logic [31:0] d_base [2];
  logic [31:0] wdat   [2][2];
  int          ccw_cyc[2], ccinv_cyc[2], d_low[2], i_low[2];
  logic [31:0] snp_addr[2];
  int          both_low, ram_act, last_d, first_i;
  logic [31:0] dq0[$], dq1[$], iq_data[$];
  int          iq_core[$];
  int          wbase;

  task automatic clear_req();
    cctrans = '0; ccwrite = '0; dREN = '0; dWEN = '0; iREN = '0;
    d_active = '0; i_active = '0;
  endtask

  task automatic start_d(input int c, input logic [31:0] base, input logic rd,
                         input logic wr, input logic ccw, input int need);
    daddr[c] = base; dstore[c] = wdat[c][0]; d_base[c] = base; d_cnt[c] = 0;
    cctrans[c] = 1'b1; dREN[c] = rd; dWEN[c] = wr; ccwrite[c] = ccw;
    d_need[c] = need; d_active[c] = 1'b1;
  endtask

  task automatic set_snooped(input int c, input logic [31:0] base);
    daddr[c] = base; dstore[c] = wdat[c][0]; d_base[c] = base; d_cnt[c] = 0;
  endtask

  task automatic run(input string name, input int max_cyc);
    int cyc;
    logic [1:0] adv, iadv;
    for (int c = 0; c < 2; c++) begin
      ccw_cyc[c] = 0; ccinv_cyc[c] = 0; d_low[c] = 0; i_low[c] = 0; snp_addr[c] = '0;
    end
    both_low = 0; ram_act = 0; last_d = 0; first_i = 0;
    dq0.delete(); dq1.delete(); iq_data.delete(); iq_core.delete();
    wbase = wa_q.size();
    cyc = 0;
    while ((d_active != 0 || i_active != 0) && cyc < max_cyc) begin
      @(negedge CLK);
      cyc++;
      adv  = ~dwait;
      iadv = ~iwait & i_active;
      for (int c = 0; c < 2; c++) begin
        if (ccwait[c]) ccw_cyc[c]++;
        if (ccinv[c]) begin ccinv_cyc[c]++; snp_addr[c] = ccsnoopaddr[c]; end
        if (adv[c]) d_low[c]++;
        if (iadv[c]) begin
          i_low[c]++;
          iq_core.push_back(c);
          iq_data.push_back(iload[c]);
          if (first_i == 0) first_i = cyc;
        end
      end
      if (dwait == 2'b00) both_low++;
      if (ramREN || ramWEN) ram_act++;
      if (adv[0]) dq0.push_back(dload[0]);
      if (adv[1]) dq1.push_back(dload[1]);
      if (adv != 2'b00) last_d = cyc;
      @(posedge CLK);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (adv[c]) begin
          d_cnt[c]++;
          if (d_active[c] && d_cnt[c] >= d_need[c]) begin
            cctrans[c] = 1'b0; ccwrite[c] = 1'b0; dREN[c] = 1'b0; dWEN[c] = 1'b0;
            d_active[c] = 1'b0;
          end else begin
            daddr[c]  = d_base[c] + 32'd4;
            dstore[c] = wdat[c][1];
          end
        end
        if (iadv[c]) begin iREN[c] = 1'b0; i_active[c] = 1'b0; end
      end
    end
    check({name, " completes"}, {62'd0, d_active != 0, i_active != 0}, 64'd0);
  endtask

  function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    lat = 1;
    hit_en = '0;
    clear_req();
    iaddr[0] = 32'h40; iaddr[1] = 32'h80;
    daddr[0] = 32'h100; daddr[1] = 32'h200;
    dstore = '0;
    for (int i = 0; i < 2; i++) begin wdat[i][0] = '0; wdat[i][1] = '0; end
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'hAAAA; mem[32'h104 >> 2] = 32'hBBBB;
    mem[32'h200 >> 2] = 32'h5555; mem[32'h204 >> 2] = 32'h6666;
    mem[32'h40  >> 2] = 32'h1234; mem[32'h80  >> 2] = 32'h5678;

    //            cct    ccw    ren    wen    iren   ccwait ccinv  dwait  iwait  ren   wen   addr
    tbl[0] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 32'h100};
    tbl[3] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0, 32'h80};
    tbl[4] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 32'h200};
    tbl[5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0, 32'h40};
    tbl[7] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0};

    repeat (2) @(negedge CLK);
    check("reset outputs", {54'd0, iwait, dwait, ccwait, ccinv, ramREN, ramWEN},
          {54'd0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0});
    check("reset snoopaddr", {ccsnoopaddr}, 64'd0);
    RST = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      cctrans = tbl[i].cct; ccwrite = tbl[i].ccw; dREN = tbl[i].ren;
      dWEN = tbl[i].wen; iREN = tbl[i].iren;
      @(negedge CLK);
      check($sformatf("vec%0d grant", i),
            {22'd0, ccwait, ccinv, dwait, iwait, ramREN, ramWEN, ramaddr},
            {22'd0, tbl[i].e_ccwait, tbl[i].e_ccinv, tbl[i].e_dwait, tbl[i].e_iwait,
             tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr});
      clear_req();
      repeat (8) @(negedge CLK);
      check($sformatf("vec%0d idle", i), {56'd0, ramREN, ramWEN, ccwait, dwait, iwait},
            {56'd0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11});
    end

    // Reset in the middle of the second load word; rr was left at 1 by the table.
    begin
      logic got;
      got = 1'b0;
      start_d(0, 32'h100, 1'b1, 1'b0, 1'b0, 2);
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge CLK);
        if (!dwait[0]) got = 1'b1;
      end
      check("rst reach ld1", {63'd0, got}, 64'd1);
      @(posedge CLK);
      #1;
      check("rst pre ld1 busy", {63'd0, ramREN}, 64'd1);
      RST = 1'b1;
      #1;
      check("rst mid ld1", {56'd0, dwait, iwait, ramREN, ramWEN, ccwait},
            {56'd0, 2'b11, 2'b11, 1'b0, 1'b0, 2'b00});
      clear_req();
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
    end

    // Simultaneous writebacks: core0 must go first after reset.
    wdat[0][0] = 32'hC0; wdat[0][1] = 32'hC1; wdat[1][0] = 32'hD0; wdat[1][1] = 32'hD1;
    start_d(0, 32'h500, 1'b0, 1'b1, 1'b0, 2);
    start_d(1, 32'h600, 1'b0, 1'b1, 1'b0, 2);
    run("dual wb", 40);
    check("dual wb count", wa_q.size() - wbase, 64'd4);
    check("dual wb w0", {qd(wa_q, wbase + 0), qd(wd_q, wbase + 0)}, {32'h500, 32'hC0});
    check("dual wb w1", {qd(wa_q, wbase + 1), qd(wd_q, wbase + 1)}, {32'h504, 32'hC1});
    check("dual wb w2", {qd(wa_q, wbase + 2), qd(wd_q, wbase + 2)}, {32'h600, 32'hD0});
    check("dual wb w3", {qd(wa_q, wbase + 3), qd(wd_q, wbase + 3)}, {32'h604, 32'hD1});

    // Both icaches: rr should be back at 0, so core0 fetches first.
    iREN = 2'b11; i_active = 2'b11;
    run("dual if", 30);
    check("dual if first", {qd(iq_data, 0), 31'd0, iq_core.size() > 0 ? iq_core[0][0] : 1'b1},
          {32'h1234, 32'd0});
    check("dual if second", {qd(iq_data, 1), 31'd0, iq_core.size() > 1 ? iq_core[1][0] : 1'b0},
          {32'h5678, 32'd1});

    // Clean block load with two BUSY cycles per word.
    lat = 2;
    start_d(0, 32'h100, 1'b1, 1'b0, 1'b0, 2);
    run("load", 40);
    check("load snoop cycles", ccw_cyc[1], 64'd1);
    check("load dwait lows", d_low[0], 64'd2);
    check("load words", {qd(dq0, 0), qd(dq0, 1)}, {32'hAAAA, 32'hBBBB});
    check("load no ram write", wa_q.size() - wbase, 64'd0);

    // Read-for-ownership hitting a Modified copy in core0: forward.
    lat = 1;
    hit_en = 2'b01;
    wdat[0][0] = 32'h11; wdat[0][1] = 32'h22;
    set_snooped(0, 32'h200);
    start_d(1, 32'h200, 1'b1, 1'b0, 1'b1, 2);
    run("forward", 40);
    check("fwd ccinv cycles", ccinv_cyc[0], 64'd1);
    check("fwd snoop addr", snp_addr[0], 64'h200);
    check("fwd joint dwait lows", both_low, 64'd2);
    check("fwd data", {qd(dq1, 0), qd(dq1, 1)}, {32'h11, 32'h22});
    check("fwd ram w0", {qd(wa_q, wbase + 0), qd(wd_q, wbase + 0)}, {32'h200, 32'h11});
    check("fwd ram w1", {qd(wa_q, wbase + 1), qd(wd_q, wbase + 1)}, {32'h204, 32'h22});
    hit_en = 2'b00;

    // icache fetch waits behind a concurrent dcache load.
    iREN[0] = 1'b1; i_active[0] = 1'b1;
    start_d(1, 32'h200, 1'b1, 1'b0, 1'b0, 2);
    run("d before i", 40);
    check("dbi dload", {qd(dq1, 0), qd(dq1, 1)}, {32'h5555, 32'h6666});
    check("dbi iload", {qd(iq_data, 0), 32'd0}, {32'h1234, 32'd0});
    check("dbi iwait lows", i_low[0], 64'd1);
    check("dbi order", {63'd0, first_i > last_d}, 64'd1);

    // Write upgrade: invalidate only, no RAM traffic.
    set_snooped(0, 32'h0);
    start_d(1, 32'h300, 1'b0, 1'b0, 1'b1, 1);
    run("upgrade", 20);
    check("upg ram idle", ram_act, 64'd0);
    check("upg ccinv cycles", ccinv_cyc[0], 64'd1);
    check("upg ccwait cycles", ccw_cyc[0], 64'd1);
    check("upg snoop addr", snp_addr[0], 64'h300);
    check("upg dwait lows", d_low[1], 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Two-core snooping bus controller: shares one RAM port between both cores' icaches and dcaches and sequences MSI coherence transactions between the two dcaches.
- Sits between the per-core caches and the RAM model.
- Serves two-word dcache blocks word by word: load, writeback, cache-to-cache forward and invalidate-only upgrade. Also serves single-word icache fetches.

Parameters:
WORD_W, 32, data/address word width
NCPU, 2, number of cores (only 2 supported; elaboration error otherwise)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
iREN  in  2  icache read request per core
iaddr  in  2xWORD_W  icache fetch address per core
iwait  out  2  icache stall; low for one cycle when iload valid
iload  out  2xWORD_W  fetched word per core
dREN  in  2  dcache read (block fill) per core
dWEN  in  2  dcache write (writeback/forward word) per core
daddr  in  2xWORD_W  dcache word address per core (cache steps word0/word1)
dstore  in  2xWORD_W  dcache write data per core
dwait  out  2  dcache stall; low for one cycle per completed word
dload  out  2xWORD_W  fill data per core
cctrans  in  2  dcache requests a bus transaction
ccwrite  in  2  requester intends to modify (invalidate other copies)
cchit  in  2  snooped cache holds ccsnoopaddr in Modified; combinational response
ccwait  out  2  core is being snooped; must stall
ccinv  out  2  invalidate snooped block
ccsnoopaddr  out  2xWORD_W  address to snoop
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

Behaviour:
- Reset (async, RST=1): state=BUS_IDLE, rr=0, gnt=0. Outputs: iwait=2'b11, dwait=2'b11, ccwait=0, ccinv=0, ramREN=ramWEN=0, ccsnoopaddr=0.
- RST asserted mid-transaction aborts immediately; no partial RAM write is retried.
- All outputs are decoded combinationally from the registered state and gnt. The opposite core is o = ~gnt.
- Arbitration in BUS_IDLE:
  - A dcache request (cctrans=1) always beats an icache request.
  - Among equal-class requesters, the core numbered rr wins if it requests, otherwise the other core.
  - gnt is registered; the transaction starts the next cycle.
  - rr <= ~gnt when a transaction returns to BUS_IDLE.
- Transitions out of BUS_IDLE, by granted request:
  - dWEN → BUS_WB0.
  - dREN → BUS_SNOOP.
  - cctrans & ccwrite & ~dREN & ~dWEN → BUS_INV.
  - iREN → BUS_IF.
  - No request → stay in BUS_IDLE.
- BUS_SNOOP (1 cycle):
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[gnt], ccinv[o]=ccwrite[gnt].
  - cchit[o] → BUS_FWD0, else → BUS_LD0.
- BUS_FWD0/1:
  - Drives ccwait[o]=1, ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[gnt]=dstore[o].
  - On ramstate==ACCESS: dwait[gnt]=0, dwait[o]=0. FWD0→FWD1, FWD1→BUS_IDLE.
- BUS_LD0/1:
  - Drives ramREN=1, ramaddr=daddr[gnt], dload[gnt]=ramload.
  - On ACCESS: dwait[gnt]=0. LD0→LD1, LD1→BUS_IDLE.
- BUS_WB0/1:
  - Drives ramWEN=1, ramaddr=daddr[gnt], ramstore=dstore[gnt].
  - On ACCESS: dwait[gnt]=0. Advance as for LD.
- BUS_INV (1 cycle):
  - ccwait[o]=1, ccinv[o]=1, ccsnoopaddr[o]=daddr[gnt], dwait[gnt]=0.
  - → BUS_IDLE. No RAM access.
- BUS_IF:
  - Drives ramREN=1, ramaddr=iaddr[gnt], iload[gnt]=ramload.
  - On ACCESS: iwait[gnt]=0 → BUS_IDLE.
- RAM status handling: BUSY, FREE and ERROR hold the current state with the request held (retry). Only ACCESS completes a word.
- Simultaneous requests: both cores' dcache requests in the same cycle are resolved by rr. An icache request waits until no cctrans is asserted.
- Non-granted requesters see wait=1 throughout.

Decomposition:
- caches_types_pkg additions:
  - bus_state_t enum (BUS_IDLE, BUS_SNOOP, BUS_FWD0, BUS_FWD1, BUS_LD0, BUS_LD1, BUS_WB0, BUS_WB1, BUS_INV, BUS_IF).
  - A localparam BLOCK_WORDS=2.
- ramstate_t comes from cpu_types_pkg.
- One sub-module: rr_arb2. Combinational 2-way round-robin pick; inputs are request vector and rr; outputs are grant index and valid. It is instantiated twice (dcache class, icache class).

Test Plan:
- Reset: assert RST mid-BUS_LD1 → next cycle state BUS_IDLE, dwait=2'b11, ramREN=0, rr=0.
- Core0 dREN addr 0x100/0x104, cchit[1]=0, RAM returns 0xAAAA/0xBBBB with 2 BUSY cycles each → ccwait[1] high only in the SNOOP cycle; dload[0]=0xAAAA then 0xBBBB; exactly two 1-cycle dwait[0] lows.
- Core1 dREN 0x200 with ccwrite=1, core0 cchit=1, dstore[0]=0x11/0x22 → ccinv[0]=1 in SNOOP; RAM writes 0x200=0x11, 0x204=0x22; dload[1] matches; dwait[0] and dwait[1] low together per word.
- Both cores assert cctrans+dWEN in the same cycle, rr=0 → core0 WB0/WB1 first, then core1; rr ends 0.
- Core0 iREN 0x40 concurrent with core1 cctrans dREN → dcache transaction completes first; then iload[0]=ramload, iwait[0] low one cycle.
- Core1 write-upgrade (cctrans, ccwrite, no dREN/dWEN) at 0x300 → one BUS_INV cycle with ccinv[0]=1, ccsnoopaddr[0]=0x300, dwait[1]=0; ramREN=ramWEN=0 throughout.
